// File: rtl/register_file.sv
// 32 x DATA_WIDTH architectural register file: two combinational read ports with
// same-cycle write forwarding, one synchronous write port, X31 hardwired to zero.
module register_file #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  RegWrite,
   input  logic [4:0]            WriteRegister,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic [4:0]            ReadRegister1,
   input  logic [4:0]            ReadRegister2,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2
);

   localparam logic [4:0] ZERO_REG = 5'(NUM_REGS - 1);

   // Only X0..X30 have storage; enable bit 31 of the one-hot decode is never built.
   logic [DATA_WIDTH-1:0] regs [0:NUM_REGS-2];
   logic [NUM_REGS-2:0]   write_enable;
   logic                  fwd1;
   logic                  fwd2;

   always_comb begin
      write_enable = '0;
      for (int i = 0; i < NUM_REGS - 1; i++) begin
         write_enable[i] = RegWrite && (WriteRegister == 5'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS - 1; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (write_enable[i]) begin
               regs[i] <= WriteData;
            end
         end
      end
   end

   // Forwarding stays combinational even while reset is asserted.
   assign fwd1 = RegWrite && (WriteRegister != ZERO_REG) && (ReadRegister1 == WriteRegister);
   assign fwd2 = RegWrite && (WriteRegister != ZERO_REG) && (ReadRegister2 == WriteRegister);

   always_comb begin
      ReadData1 = '0;
      if (fwd1) begin
         ReadData1 = WriteData;
      end else if (ReadRegister1 != ZERO_REG) begin
         ReadData1 = regs[ReadRegister1];
      end
   end

   always_comb begin
      ReadData2 = '0;
      if (fwd2) begin
         ReadData2 = WriteData;
      end else if (ReadRegister2 != ZERO_REG) begin
         ReadData2 = regs[ReadRegister2];
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Directed plus randomized checks of register_file against an array-based model
// of the architectural register state.
module tb_register_file;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         RegWrite;
  logic [4:0]   WriteRegister;
  logic [W-1:0] WriteData;
  logic [4:0]   ReadRegister1;
  logic [4:0]   ReadRegister2;
  logic [W-1:0] ReadData1;
  logic [W-1:0] ReadData2;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] model [0:31];

  register_file #(.DATA_WIDTH(W), .NUM_REGS(32)) dut (
    .clk(clk),
    .reset(reset),
    .RegWrite(RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData(WriteData),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: architectural value seen by a read of idx this cycle
  function automatic logic [W-1:0] exp_read(input logic [4:0] idx, input logic we,
                                            input logic [4:0] wr, input logic [W-1:0] wd);
    if (we && wr != 5'd31 && idx == wr) return wd;
    if (idx == 5'd31) return '0;
    return model[idx];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive, check combinational reads, commit edge to model
  task automatic cycle(input logic rst, input logic we, input logic [4:0] wr,
                       input logic [W-1:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                       input bit chk);
    reset = rst;
    RegWrite = we;
    WriteRegister = wr;
    WriteData = wd;
    ReadRegister1 = r1;
    ReadRegister2 = r2;
    #2;
    if (chk) begin
      check($sformatf("rd1_r%0d", r1), ReadData1, exp_read(r1, we, wr, wd));
      check($sformatf("rd2_r%0d", r2), ReadData2, exp_read(r2, we, wr, wd));
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (we && wr != 5'd31) begin
      model[wr] = wd;
    end
    #1;
  endtask

  // read every index on both ports with writes disabled
  task automatic sweep(input string tag);
    reset = 1'b0;
    RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #1;
      check($sformatf("%s_p1_r%0d", tag, i), ReadData1, exp_read(5'(i), 1'b0, 5'd0, '0));
      check($sformatf("%s_p2_r%0d", tag, 31 - i), ReadData2, exp_read(5'(31 - i), 1'b0, 5'd0, '0));
    end
  endtask

  initial begin
    logic         we;
    logic [4:0]   wr;
    logic [4:0]   r1;
    logic [4:0]   r2;
    logic [W-1:0] wd;

    for (int i = 0; i < 32; i++) model[i] = '0;
    reset = 1'b1;
    RegWrite = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    @(posedge clk);
    #1;

    // reset clear
    cycle(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0);
    sweep("rst0");
    cycle(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd5, 5'd0, 1'b1);
    check("x5_stored", ReadData1, 64'hDEAD_BEEF_0000_0001);
    cycle(1'b1, 1'b0, 5'd0, '0, 5'd5, 5'd5, 1'b1);
    sweep("rst1");
    cycle(1'b0, 1'b1, 5'd7, 64'h55, 5'd7, 5'd0, 1'b1);
    cycle(1'b1, 1'b1, 5'd7, 64'h1234, 5'd0, 5'd0, 1'b1);
    RegWrite = 1'b0;
    reset = 1'b0;
    ReadRegister1 = 5'd7;
    #1;
    check("rst_beats_write", ReadData1, 64'h0);

    // write/read all
    for (int i = 0; i <= 30; i++) begin
      cycle(1'b0, 1'b1, 5'(i), 64'(i) * 64'h0101_0101_0101_0101, 5'(i), 5'(30 - i), 1'b1);
    end
    for (int i = 0; i <= 30; i++) begin
      cycle(1'b0, 1'b0, 5'd0, '0, 5'(i), 5'(30 - i), 1'b1);
    end
    sweep("all");

    // X31 hardwire
    cycle(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 1'b1);
    cycle(1'b0, 1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 1'b1);
    check("x31_zero", ReadData1, 64'h0);
    sweep("x31");

    // write disable
    cycle(1'b0, 1'b1, 5'd3, 64'hAAAA, 5'd3, 5'd3, 1'b1);
    cycle(1'b0, 1'b0, 5'd3, 64'h5555, 5'd3, 5'd3, 1'b1);
    cycle(1'b0, 1'b0, 5'd3, 64'h5555, 5'd3, 5'd3, 1'b1);
    check("wdis_p1", ReadData1, 64'hAAAA);
    check("wdis_p2", ReadData2, 64'hAAAA);

    // forwarding on both ports
    cycle(1'b0, 1'b1, 5'd9, 64'h10, 5'd0, 5'd1, 1'b1);
    cycle(1'b0, 1'b1, 5'd9, 64'h20, 5'd9, 5'd9, 1'b1);
    RegWrite = 1'b0;
    #1;
    check("fwd_store_p1", ReadData1, 64'h20);
    check("fwd_store_p2", ReadData2, 64'h20);

    // back-to-back writes to X12
    for (int k = 1; k <= 3; k++) begin
      RegWrite = 1'b1;
      WriteRegister = 5'd12;
      WriteData = 64'(k);
      ReadRegister1 = 5'd12;
      #2;
      check($sformatf("b2b_%0d", k), ReadData1, 64'(k));
      cycle(1'b0, 1'b1, 5'd12, 64'(k), 5'd12, 5'd12, 1'b1);
    end
    cycle(1'b0, 1'b0, 5'd12, 64'h0, 5'd12, 5'd12, 1'b1);
    check("b2b_persist", ReadData1, 64'h3);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 3) != 0);
      wr = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 63) == 0), we, wr, wd, r1, r2, 1'b1);
    end
    sweep("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
